// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-to-one memory port arbiter.
//   OWNER_INSTR / OWNER_DATA : 1-bit owner tags stored in the owner FIFO
//   arb_state_t              : arbiter FSM state (ARB, LOCK)
package mem_bus_arbiter_pkg;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bus used for the fetch port, the load/store port and the
// memory port of the arbiter.
//   req/we/be/addr/wdata : request phase, driven by the master
//   gnt                  : request accepted, driven by the slave
//   valid/rdata/err      : response, driven by the slave
//
// Handshake: a master raises req with a payload and holds req and payload
// stable until the cycle in which gnt is high; that cycle transfers the
// request. Responses return in request order, one per valid cycle, and are
// never back-pressured (the master always accepts them).
interface mem_bus_arbiter_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, valid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, valid, rdata, err
    );

endinterface

// File: rtl/mem_bus_arbiter_owner_fifo.sv
// Owner FIFO: remembers which requester owns each granted-but-unanswered
// memory transaction, oldest at the head.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : append push_owner (never asserted while full)
//   pop        : drop the head entry (never asserted while empty)
//   head_owner : owner of the oldest outstanding transaction
//   count      : number of stored entries
//   full       : count == DEPTH
module arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       push_owner,
    input  logic                       pop,
    output logic                       head_owner,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_owner;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_owner = slots[rd_ptr];
    assign full       = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-to-one arbiter sharing one memory port between instruction fetch and
// load/store. One request is forwarded per cycle; in-order memory responses
// are steered back to the requester that owns them.
//   clk, reset  : clock, synchronous active-high reset
//   instr       : fetch requester (slave side; we/be/wdata are ignored)
//   data        : load/store requester (slave side)
//   mem         : memory port (master side)
//   arb_err     : one-cycle pulse when a response arrives with nothing outstanding
//   dbg_state   : current FSM state, for observation only
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_bus_arbiter_if.slave         instr,
    mem_bus_arbiter_if.slave         data,
    mem_bus_arbiter_if.master        mem,
    output logic                     arb_err,
    output arb_state_t               dbg_state
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    arb_state_t       state, state_next;
    logic             last_owner, last_owner_next;
    logic             lock_owner, lock_owner_next;
    logic             sel_owner;
    logic             sel_valid;
    logic             mem_grant;
    logic             resp_valid;
    logic             pop;
    logic             head_owner;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Requester selection. In LOCK the offered request must stay on the bus
    // until memory takes it, so the other requester is ignored.
    always_comb begin
        sel_owner = OWNER_INSTR;
        sel_valid = 1'b0;
        case (state)
            LOCK: begin
                sel_owner = lock_owner;
                sel_valid = (lock_owner == OWNER_DATA) ? data.req : instr.req;
            end
            default: begin
                if (instr.req && data.req) begin
                    sel_owner = (last_owner == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
                end else if (data.req) begin
                    sel_owner = OWNER_DATA;
                end else begin
                    sel_owner = OWNER_INSTR;
                end
                sel_valid = instr.req || data.req;
            end
        endcase
    end

    // Request path. The full check uses the registered count, so a response
    // popping in the same cycle does not open a slot until the next cycle.
    always_comb begin
        mem.req   = sel_valid && !fifo_full && !reset;
        mem.we    = 1'b0;
        mem.be    = 4'hF;
        mem.addr  = instr.addr;
        mem.wdata = '0;
        if (sel_owner == OWNER_DATA) begin
            mem.we    = data.we;
            mem.be    = data.be;
            mem.addr  = data.addr;
            mem.wdata = data.wdata;
        end
    end

    assign mem_grant = mem.req && mem.gnt;
    assign instr.gnt = mem_grant && (sel_owner == OWNER_INSTR);
    assign data.gnt  = mem_grant && (sel_owner == OWNER_DATA);

    // Response demux. A response with nothing outstanding is an orphan
    // (e.g. answer to a transaction granted before reset): drop and flag it.
    assign resp_valid = mem.valid && !reset;
    assign pop        = resp_valid && (fifo_count != '0);
    assign arb_err    = resp_valid && (fifo_count == '0);

    always_comb begin
        instr.valid = pop && (head_owner == OWNER_INSTR);
        data.valid  = pop && (head_owner == OWNER_DATA);
        instr.rdata = instr.valid ? mem.rdata : '0;
        instr.err   = instr.valid ? mem.err   : 1'b0;
        data.rdata  = data.valid  ? mem.rdata : '0;
        data.err    = data.valid  ? mem.err   : 1'b0;
    end

    // FSM next state: an offered but unaccepted request locks the selection.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        lock_owner_next = lock_owner;
        case (state)
            ARB: begin
                if (mem_grant) begin
                    last_owner_next = sel_owner;
                end else if (mem.req) begin
                    lock_owner_next = sel_owner;
                    state_next      = LOCK;
                end
            end
            LOCK: begin
                if (mem_grant) begin
                    last_owner_next = sel_owner;
                    state_next      = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            last_owner <= OWNER_INSTR;
            lock_owner <= OWNER_INSTR;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            lock_owner <= lock_owner_next;
        end
    end

    assign dbg_state = state;

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (mem_grant),
        .push_owner (sel_owner),
        .pop        (pop),
        .head_owner (head_owner),
        .count      (fifo_count),
        .full       (fifo_full)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// (owner queue, last winner, offered-request memory).
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int OUTSTANDING = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic        ireq = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dreq = 1'b0;
    logic        dwe = 1'b0;
    logic [3:0]  dbe = 4'h0;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic        mgnt = 1'b0;
    logic        mvalid = 1'b0;
    logic [31:0] mrdata = '0;
    logic        merr = 1'b0;

    mem_bus_arbiter_if instr_bus ();
    mem_bus_arbiter_if data_bus ();
    mem_bus_arbiter_if mem_bus ();

    logic       arb_err;
    arb_state_t dbg_state;

    assign instr_bus.req   = ireq;
    assign instr_bus.we    = 1'b0;
    assign instr_bus.be    = 4'h0;
    assign instr_bus.addr  = iaddr;
    assign instr_bus.wdata = '0;
    assign data_bus.req    = dreq;
    assign data_bus.we     = dwe;
    assign data_bus.be     = dbe;
    assign data_bus.addr   = daddr;
    assign data_bus.wdata  = dwdata;
    assign mem_bus.gnt     = mgnt;
    assign mem_bus.valid   = mvalid;
    assign mem_bus.rdata   = mrdata;
    assign mem_bus.err     = merr;

    mem_bus_arbiter #(
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .instr     (instr_bus),
        .data      (data_bus),
        .mem       (mem_bus),
        .arb_err   (arb_err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [0:0] exp_q[$];      // owners of outstanding transactions, oldest first
    logic       last_winner = OWNER_INSTR;
    logic       offered = 1'b0;
    logic       offered_who = OWNER_INSTR;
    logic       m_i_gnt = 1'b0;
    logic       m_d_gnt = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate one cycle: settle, compare the DUT against the model, advance
    // the model to its post-edge state.
    task automatic eval();
        logic        who, want, exp_req, granted, have_head, head, iv, dv;
        #1;
        if (rst) begin
            chk("rst_mem_req", mem_bus.req, 0);
            chk("rst_instr_gnt", instr_bus.gnt, 0);
            chk("rst_data_gnt", data_bus.gnt, 0);
            chk("rst_instr_valid", instr_bus.valid, 0);
            chk("rst_data_valid", data_bus.valid, 0);
            chk("rst_arb_err", arb_err, 0);
            exp_q.delete();
            last_winner = OWNER_INSTR;
            offered     = 1'b0;
            m_i_gnt     = 1'b0;
            m_d_gnt     = 1'b0;
        end else begin
            if (offered) begin
                who  = offered_who;
                want = 1'b1;
            end else if (ireq && dreq) begin
                who  = (last_winner == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
                want = 1'b1;
            end else begin
                who  = dreq ? OWNER_DATA : OWNER_INSTR;
                want = ireq || dreq;
            end
            exp_req = want && (exp_q.size() < OUTSTANDING);
            granted = exp_req && mgnt;
            chk("mem_req", mem_bus.req, exp_req);
            if (exp_req) begin
                chk("mem_addr", mem_bus.addr, (who == OWNER_DATA) ? daddr : iaddr);
                chk("mem_we", mem_bus.we, (who == OWNER_DATA) ? dwe : 1'b0);
                chk("mem_be", mem_bus.be, (who == OWNER_DATA) ? dbe : 4'hF);
                chk("mem_wdata", mem_bus.wdata, (who == OWNER_DATA) ? dwdata : 32'h0);
            end
            chk("instr_gnt", instr_bus.gnt, granted && (who == OWNER_INSTR));
            chk("data_gnt", data_bus.gnt, granted && (who == OWNER_DATA));

            have_head = mvalid && (exp_q.size() > 0);
            head      = have_head ? exp_q[0] : OWNER_INSTR;
            iv        = have_head && (head == OWNER_INSTR);
            dv        = have_head && (head == OWNER_DATA);
            chk("instr_valid", instr_bus.valid, iv);
            chk("instr_rdata", instr_bus.rdata, iv ? mrdata : 32'h0);
            chk("instr_err", instr_bus.err, iv ? merr : 1'b0);
            chk("data_valid", data_bus.valid, dv);
            chk("data_rdata", data_bus.rdata, dv ? mrdata : 32'h0);
            chk("data_err", data_bus.err, dv ? merr : 1'b0);
            chk("arb_err", arb_err, mvalid && (exp_q.size() == 0));

            if (have_head) void'(exp_q.pop_front());
            if (granted) begin
                exp_q.push_back(who);
                last_winner = who;
                offered     = 1'b0;
            end else if (exp_req) begin
                offered     = 1'b1;
                offered_who = who;
            end
            m_i_gnt = granted && (who == OWNER_INSTR);
            m_d_gnt = granted && (who == OWNER_DATA);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic adv();
        @(negedge clk);
    endtask

    task automatic idle();
        ireq = 1'b0; dreq = 1'b0; mgnt = 1'b0;
        mvalid = 1'b0; mrdata = '0; merr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        eval();
        chk("reset_mem_req", mem_bus.req, 0);
        adv();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            mvalid = 1'b1;
            mrdata = 32'hD0 + i;
            eval();
            adv();
        end
        idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        adv();
        do_reset();

        // Single fetch with zero-latency grant, response next cycle.
        ireq = 1'b1; iaddr = 32'h100; mgnt = 1'b1;
        eval();
        chk("fetch_gnt", instr_bus.gnt, 1);
        chk("fetch_addr", mem_bus.addr, 32'h100);
        chk("fetch_be", mem_bus.be, 4'hF);
        adv();
        ireq = 1'b0; mgnt = 1'b0; mvalid = 1'b1; mrdata = 32'h13;
        eval();
        chk("fetch_valid", instr_bus.valid, 1);
        chk("fetch_rdata", instr_bus.rdata, 32'h13);
        chk("fetch_data_valid", data_bus.valid, 0);
        adv();
        idle();

        // Tie after reset: data, instr, data, instr; responses in that order.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ireq = (k < 4); dreq = (k < 4);
            iaddr = 32'h1000 + k / 2;
            daddr = 32'h2000 + (k + 1) / 2;
            dwe = 1'b1; dbe = 4'h3; dwdata = 32'hCAFE0000 + k;
            mgnt = (k < 4); mvalid = (k > 0); mrdata = 32'hA0 + k;
            eval();
            if (k < 4) begin
                chk("tie_data_gnt", data_bus.gnt, (k % 2) == 0);
                chk("tie_instr_gnt", instr_bus.gnt, (k % 2) == 1);
                chk("tie_addr", mem_bus.addr, ((k % 2) == 0) ? 32'h2000 + k / 2 : 32'h1000 + k / 2);
            end
            if (k > 0) begin
                chk("tie_resp_data", data_bus.valid, ((k - 1) % 2) == 0);
                chk("tie_resp_instr", instr_bus.valid, ((k - 1) % 2) == 1);
            end
            adv();
        end
        idle();

        // Lock: memory stalls 3 cycles, address stays on the first winner.
        do_reset();
        ireq = 1'b1; iaddr = 32'h200;
        dreq = 1'b1; daddr = 32'h300; dwe = 1'b0; dbe = 4'hF; dwdata = '0;
        for (int k = 0; k < 4; k++) begin
            mgnt = (k == 3);
            eval();
            chk("lock_addr", mem_bus.addr, 32'h300);
            chk("lock_data_gnt", data_bus.gnt, k == 3);
            chk("lock_instr_gnt", instr_bus.gnt, 0);
            adv();
        end
        daddr = 32'h304;
        eval();
        chk("lock_next_instr_gnt", instr_bus.gnt, 1);
        chk("lock_next_addr", mem_bus.addr, 32'h200);
        adv();
        drain(2);

        // Full: two grants, third request held off until a slot frees.
        do_reset();
        ireq = 1'b1; iaddr = 32'h400; mgnt = 1'b1;
        eval();
        chk("full_gnt0", instr_bus.gnt, 1);
        adv();
        iaddr = 32'h404;
        eval();
        chk("full_gnt1", instr_bus.gnt, 1);
        adv();
        iaddr = 32'h408;
        eval();
        chk("full_req_blocked", mem_bus.req, 0);
        chk("full_gnt_blocked", instr_bus.gnt, 0);
        adv();
        mvalid = 1'b1; mrdata = 32'h55;
        eval();
        chk("full_pop_same_cycle", mem_bus.req, 0);
        chk("full_pop_valid", instr_bus.valid, 1);
        adv();
        mvalid = 1'b0;
        eval();
        chk("full_freed_req", mem_bus.req, 1);
        chk("full_freed_gnt", instr_bus.gnt, 1);
        adv();
        drain(2);

        // Orphan response with nothing outstanding.
        idle();
        mvalid = 1'b1; mrdata = 32'h77; merr = 1'b1;
        eval();
        chk("orphan_arb_err", arb_err, 1);
        chk("orphan_instr_valid", instr_bus.valid, 0);
        chk("orphan_data_valid", data_bus.valid, 0);
        chk("orphan_instr_rdata", instr_bus.rdata, 0);
        adv();
        idle();
        eval();
        chk("orphan_pulse_end", arb_err, 0);
        adv();

        // Reset with two outstanding: outputs quiet, later responses orphaned.
        ireq = 1'b1; iaddr = 32'h500; mgnt = 1'b1;
        eval(); adv();
        iaddr = 32'h504;
        eval(); adv();
        rst = 1'b1; iaddr = 32'h508; mvalid = 1'b1;
        eval();
        chk("midrst_mem_req", mem_bus.req, 0);
        chk("midrst_instr_gnt", instr_bus.gnt, 0);
        chk("midrst_instr_valid", instr_bus.valid, 0);
        chk("midrst_arb_err", arb_err, 0);
        adv();
        rst = 1'b0; ireq = 1'b0; mgnt = 1'b0; mvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("midrst_orphan_err", arb_err, 1);
            chk("midrst_orphan_valid", instr_bus.valid, 0);
            adv();
        end
        idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if (m_i_gnt) ireq = 1'b0;
            if (!ireq && $urandom_range(0, 2) != 0) begin
                ireq  = 1'b1;
                iaddr = $urandom;
            end
            if (m_d_gnt) dreq = 1'b0;
            if (!dreq && $urandom_range(0, 2) != 0) begin
                dreq   = 1'b1;
                daddr  = $urandom;
                dwe    = 1'($urandom_range(0, 1));
                dbe    = 4'($urandom_range(0, 15));
                dwdata = $urandom;
            end
            mgnt   = ($urandom_range(0, 3) != 0);
            mvalid = (exp_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            mrdata = $urandom;
            merr   = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 299) == 0);
            eval();
            adv();
        end
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-to-one arbiter sharing a single program/data memory port between the instruction fetch requester (if_stage instruction interface) and the load/store requester. Sits between the core and the memory, forwarding one request per cycle on a req/gnt address phase and returning in-order responses (valid/rdata/err) to the requester that owns them. A small owner FIFO tracks outstanding transactions.

## Interface
- OUTSTANDING, 2: maximum granted-but-unanswered transactions on the memory port (1..4).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_req / instr_addr  in  1 / 32  fetch request, word address.
- instr_gnt  out  1  fetch request accepted.
- instr_valid / instr_rdata / instr_err  out  1 / 32 / 1  fetch response.
- data_req / data_we / data_be / data_addr / data_wdata  in  1 / 1 / 4 / 32 / 32  load/store request.
- data_gnt  out  1  load/store accepted.
- data_valid / data_rdata / data_err  out  1 / 32 / 1  load/store response.
- mem_req / mem_we / mem_be / mem_addr / mem_wdata  out  1 / 1 / 4 / 32 / 32  memory request.
- mem_gnt  in  1  memory accepted request.
- mem_valid / mem_rdata / mem_err  in  1 / 32 / 1  memory response, in request order.
- arb_err  out  1  one-cycle pulse: mem_valid received with no outstanding transaction.

## Operation
- Requesters hold req and payload stable until gnt; fetch requests drive mem_we=0, mem_be=4'hF, mem_wdata=0.
- FSM: ARB, LOCK.
  - ARB: if exactly one req, select it; if both, select the one not in last_owner (reset value: instr, so data wins the first tie). mem_req=1 if count<OUTSTANDING. mem_gnt=1 -> push owner, update last_owner, stay ARB. mem_gnt=0 -> store owner in lock_owner, go LOCK.
  - LOCK: route lock_owner only; the other requester waits. On mem_gnt: push owner, update last_owner, go ARB.
- Grant gating: mem_req is forced 0 and no gnt is forwarded while count==OUTSTANDING; a same-cycle pop does not free the slot for that cycle's grant.
- Responses: mem_valid with FIFO non-empty -> route rdata/err to the head owner's valid/rdata/err, pop. The other requester's valid=0. Responses are never stalled; requesters always accept.
- mem_valid with FIFO empty: response dropped, arb_err=1 for that cycle.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- rdata/err of the non-selected requester are driven 0.

## Timing
- Zero-latency paths: selected req/payload -> mem_*; mem_gnt -> owner gnt; mem_valid/rdata/err -> owner response (combinational).
- Minimum grant-to-response: 1 cycle (response in cycle after mem_gnt).
- State, owner FIFO, count and last_owner update on clk rising edge.
- Reset (any time, including mid-transaction): FSM=ARB, count=0, FIFO cleared, last_owner=instr. While reset=1: mem_req=0, instr_gnt=data_gnt=0, instr_valid=data_valid=0, arb_err=0. Responses to transactions granted before reset are treated as orphans (dropped, arb_err pulse).
- Back-to-back: one grant per cycle sustained while count<OUTSTANDING and memory grants every cycle.

## Structure
- Shared package: owner encoding constants OWNER_INSTR=1'b0, OWNER_DATA=1'b1; FSM state typedef (ARB, LOCK).
- Sub-module arb_owner_fifo: OUTSTANDING-deep, 1-bit wide, push/pop/count, synchronous active-high reset; full = count==OUTSTANDING.
- Top holds FSM, round-robin select, response demux.

## Test plan
- Single fetch: instr_req=1, addr=0x100, mem_gnt same cycle, mem_valid next cycle rdata=0x00000013 -> instr_gnt=1 cycle 0, instr_valid=1 rdata=0x13 cycle 1, data_valid=0.
- Tie after reset: both req, mem_gnt=1 each cycle -> grants data, instr, data, instr; responses demuxed in that order.
- Lock: both req, mem_gnt=0 for 3 cycles then 1 -> mem_addr stays on first winner's address all 4 cycles; other requester granted next.
- Full: OUTSTANDING=2, two grants, no mem_valid -> mem_req=0 third cycle despite pending req; mem_valid frees slot, next cycle mem_req=1.
- Orphan: mem_valid with count=0 -> arb_err=1 one cycle, both valid=0; also reset asserted with 2 outstanding -> all outputs 0, later responses flagged.
